// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter.
// Inhibits the bus, issues request-to-send, clocks out one byte on device clocks and checks the ACK.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       iClock,
    input  logic       iReset,
    input  logic       iPs2Clk,
    input  logic       iPs2Data,
    output logic       oPs2ClkOe,
    output logic       oPs2DataOe,
    input  logic       iStart,
    input  logic [7:0] iCmd,
    output logic       oBusy,
    output logic       oDone,
    output logic       oError
);
    localparam int IN_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IN_W-1:0] INHIBIT_LAST = IN_W'(INHIBIT_CYCLES - 1);
    localparam logic [WD_W-1:0] TIMEOUT_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] INHIBIT   = 3'd1;
    localparam logic [2:0] RTS       = 3'd2;
    localparam logic [2:0] SEND      = 3'd3;
    localparam logic [2:0] WAIT_ACK  = 3'd4;
    localparam logic [2:0] WAIT_IDLE = 3'd5;

    logic [2:0]      r_state;
    logic [9:0]      r_shift;
    logic [3:0]      r_bit_cnt;
    logic [IN_W-1:0] r_inh_cnt;
    logic [WD_W-1:0] r_wd_cnt;
    logic            r_clk_s1, r_clk_s2, r_clk_prev, r_dat_s1, r_dat_s2;
    logic            r_clk_oe, r_dat_oe, r_busy, r_done, r_error;
    logic            w_fall, w_watched, w_timeout;

    assign w_fall     = r_clk_prev & ~r_clk_s2;
    assign w_watched  = r_state inside {RTS, SEND, WAIT_ACK, WAIT_IDLE};
    assign w_timeout  = w_watched & ~w_fall & (r_wd_cnt == TIMEOUT_LAST);
    assign oPs2ClkOe  = r_clk_oe;
    assign oPs2DataOe = r_dat_oe;
    assign oBusy      = r_busy;
    assign oDone      = r_done;
    assign oError     = r_error;

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            {r_clk_s1, r_clk_s2, r_clk_prev, r_dat_s1, r_dat_s2} <= '1;
        end else begin
            r_clk_s1   <= iPs2Clk;
            r_clk_s2   <= r_clk_s1;
            r_clk_prev <= r_clk_s2;
            r_dat_s1   <= iPs2Data;
            r_dat_s2   <= r_dat_s1;
        end
    end

    // Watchdog free-runs and is cleared by every device falling edge or explicit state change.
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_inh_cnt <= '0;
            r_wd_cnt  <= '0;
            r_clk_oe  <= 1'b0;
            r_dat_oe  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_done   <= 1'b0;
            r_error  <= 1'b0;
            r_wd_cnt <= w_fall ? '0 : r_wd_cnt + 1'b1;
            if (w_timeout) begin
                r_state  <= IDLE;
                r_clk_oe <= 1'b0;
                r_dat_oe <= 1'b0;
                r_busy   <= 1'b0;
                r_error  <= 1'b1;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (iStart) begin
                            r_shift   <= {1'b1, ~^iCmd, iCmd};
                            r_bit_cnt <= '0;
                            r_inh_cnt <= '0;
                            r_wd_cnt  <= '0;
                            r_clk_oe  <= 1'b1;
                            r_busy    <= 1'b1;
                            r_state   <= INHIBIT;
                        end
                    end
                    INHIBIT: begin
                        r_inh_cnt <= r_inh_cnt + 1'b1;
                        if (r_inh_cnt == INHIBIT_LAST) begin
                            r_dat_oe <= 1'b1;
                            r_wd_cnt <= '0;
                            r_state  <= RTS;
                        end
                    end
                    RTS, SEND: begin
                        r_clk_oe <= 1'b0;
                        if (w_fall) begin
                            r_dat_oe  <= ~r_shift[0];
                            r_shift   <= {1'b1, r_shift[9:1]};
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            r_state   <= (r_bit_cnt == 4'd9) ? WAIT_ACK : SEND;
                        end
                    end
                    WAIT_ACK: begin
                        if (w_fall) begin
                            if (r_dat_s2) begin
                                r_error <= 1'b1;
                                r_busy  <= 1'b0;
                                r_state <= IDLE;
                            end else begin
                                r_state <= WAIT_IDLE;
                            end
                        end
                    end
                    WAIT_IDLE: begin
                        if (r_clk_s2 & r_dat_s2) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end
                    end
                    default: begin
                        r_clk_oe <= 1'b0;
                        r_dat_oe <= 1'b0;
                        r_busy   <= 1'b0;
                        r_state  <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: scoreboard bench for ps2_host_tx with an open-drain PS/2 device model.
module tb_ps2_host_tx;
    localparam int INH    = 8;
    localparam int TMO    = 200;
    localparam int M_ACK  = 0;
    localparam int M_NACK = 1;
    localparam int M_MUTE = 2;

    typedef struct packed {
        logic [9:0] frame;
        logic       chk_frame;
        logic       done;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] cmd = 8'h00;
    logic       clk_oe, dat_oe, busy, done, err;
    logic       dev_clk = 1'b1;
    logic       dev_dat = 1'b1;
    logic       ps2_clk, ps2_dat;
    int         dev_mode = M_ACK;
    bit         dev_abort = 1'b0;
    int         dev_nbits = 0;
    int         dev_len = 0;
    logic [9:0] rx_frame = '0;
    int         n_chk = 0;
    int         n_fail = 0;
    int         n_pulse = 0;
    exp_t       exp_q[$];
    exp_t       mon_e;

    assign ps2_clk = dev_clk & ~clk_oe;
    assign ps2_dat = dev_dat & ~dat_oe;

    always #5 clk = ~clk;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
        .iClock    (clk),
        .iReset    (rst),
        .iPs2Clk   (ps2_clk),
        .iPs2Data  (ps2_dat),
        .oPs2ClkOe (clk_oe),
        .oPs2DataOe(dat_oe),
        .iStart    (start),
        .iCmd      (cmd),
        .oBusy     (busy),
        .oDone     (done),
        .oError    (err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic issue(input logic [7:0] c);
        cmd   = c;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic wait_idle(input int lim);
        int n = 0;
        while (busy && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk("busy_released", busy, 0);
    endtask

    task automatic send(input logic [7:0] c, input int mode, input logic [9:0] frame, input logic exp_done);
        dev_mode = mode;
        exp_q.push_back({frame, 1'b1, exp_done});
        issue(c);
        wait_idle(2000);
        repeat (50) @(negedge clk);
    endtask

    // Device: measures inhibit, checks start bit, clocks 11 pulses at 40-cycle period, samples on rising edges.
    initial begin
        forever begin
            @(negedge clk);
            if (clk_oe) begin
                dev_len = 0;
                while (clk_oe) begin
                    dev_len++;
                    @(negedge clk);
                end
                if (dev_mode != M_MUTE) begin
                    chk("inhibit_len", (dev_len >= INH && dev_len <= INH + 2), 1);
                    chk("start_bit", ps2_dat, 0);
                    dev_nbits = 0;
                    rx_frame  = '0;
                    repeat (10) @(negedge clk);
                    for (int k = 0; k < 11 && !dev_abort; k++) begin
                        dev_clk = 1'b0;
                        repeat (20) @(negedge clk);
                        dev_clk = 1'b1;
                        if (k == 10) begin
                            dev_dat = 1'b1;
                        end else begin
                            rx_frame[k] = ps2_dat;
                            dev_nbits   = k + 1;
                        end
                        repeat (10) @(negedge clk);
                        if (k == 9 && dev_mode == M_ACK) dev_dat = 1'b0;
                        repeat (10) @(negedge clk);
                    end
                    dev_clk = 1'b1;
                    dev_dat = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (done || err) begin
            n_pulse++;
            chk("pulse_exclusive", {31'd0, done & err}, 0);
            chk("busy_at_pulse", busy, 0);
            chk("oe_at_pulse", {clk_oe, dat_oe}, 0);
            chk("pulse_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("outcome_done", done, mon_e.done);
                chk("outcome_error", err, !mon_e.done);
                if (mon_e.chk_frame) chk("frame", rx_frame, mon_e.frame);
            end
        end
    end

    initial begin
        int n;
        int np;
        repeat (3) @(negedge clk);
        chk("rst_clk_oe", clk_oe, 0);
        chk("rst_dat_oe", dat_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", err, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        send(8'hED, M_ACK, 10'h3ED, 1'b1);
        send(8'h01, M_ACK, 10'h201, 1'b1);
        send(8'h00, M_ACK, 10'h300, 1'b1);

        dev_mode = M_MUTE;
        exp_q.push_back({10'h000, 1'b0, 1'b0});
        issue(8'hED);
        n = 0;
        while (clk_oe && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rts_release", clk_oe, 0);
        n = 0;
        while (!err && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_latency", n, 199);
        wait_idle(10);
        repeat (20) @(negedge clk);

        send(8'hAB, M_NACK, 10'h2AB, 1'b0);

        dev_mode  = M_ACK;
        dev_nbits = 0;
        exp_q.push_back({10'h3ED, 1'b1, 1'b1});
        issue(8'hED);
        n = 0;
        while (dev_nbits < 3 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("reach_send", dev_nbits >= 3, 1);
        issue(8'h55);
        wait_idle(2000);
        repeat (50) @(negedge clk);

        dev_nbits = 0;
        issue(8'h12);
        n = 0;
        while (dev_nbits < 4 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("reach_bit4", dev_nbits >= 4, 1);
        np = n_pulse;
        #3 rst = 1'b1;
        #1;
        chk("async_rst_oe", {clk_oe, dat_oe}, 0);
        chk("async_rst_busy", busy, 0);
        dev_abort = 1'b1;
        repeat (60) @(negedge clk);
        chk("no_pulse_on_reset", n_pulse, np);
        rst = 1'b0;
        dev_abort = 1'b0;
        repeat (10) @(negedge clk);

        send(8'hF4, M_ACK, 10'h2F4, 1'b1);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter INHIBIT_CYCLES, default 5000, iClock cycles the PS/2 clock is held low before request-to-send (100 us at 50 MHz).
REQ-002 Parameter TIMEOUT_CYCLES, default 750000, max iClock cycles waited for any expected device edge before aborting (15 ms at 50 MHz).
REQ-003 iClock  input  1  system clock; the only clock in the block, all logic on its rising edge.
REQ-004 iReset  input  1  reset, asynchronous, active-high.
REQ-005 iPs2Clk  input  1  PS/2 clock line as read back from the pad (asynchronous).
REQ-006 iPs2Data  input  1  PS/2 data line as read back from the pad (asynchronous).
REQ-007 oPs2ClkOe  output  1  1 = pull PS/2 clock low; 0 = release (open-drain, pull-up external).
REQ-008 oPs2DataOe  output  1  1 = pull PS/2 data low; 0 = release.
REQ-009 iStart  input  1  one-cycle request to send iCmd.
REQ-010 iCmd  input  8  command byte (e.g. 0xED set-LEDs); captured on accepted iStart.
REQ-011 oBusy  output  1  high from accepted iStart until return to IDLE.
REQ-012 oDone  output  1  one-cycle pulse: byte sent and device ACK received.
REQ-013 oError  output  1  one-cycle pulse: transfer aborted (timeout or missing ACK).

Function
REQ-014 iPs2Clk and iPs2Data SHALL each pass a 2-flop synchronizer; a falling edge is synchronized value 1 -> 0 between consecutive cycles.
REQ-015 Frame: start 0, iCmd[0]..iCmd[7] LSB first, odd parity (XOR of iCmd inverted), stop 1 (data released), device ACK 0.
REQ-016 States: IDLE, INHIBIT, RTS, SEND, WAIT_ACK, WAIT_IDLE.
REQ-017 IDLE: both Oe low, oBusy low; iStart accepted -> latch iCmd into 10-bit shift register {stop=1, parity, iCmd}, clear bit counter, oBusy high next cycle, go INHIBIT.
REQ-018 iStart while oBusy high SHALL be ignored; iCmd changes during a transfer SHALL not affect it.
REQ-019 INHIBIT: oPs2ClkOe=1; after INHIBIT_CYCLES cycles assert oPs2DataOe=1 (start bit) and go RTS.
REQ-020 RTS: on the cycle after entry oPs2ClkOe=0 (data held low); wait for first device falling edge, then go SEND.
REQ-021 SEND: on each synchronized falling edge (the entry edge included) drive next shift-register bit (oPs2DataOe = ~bit), increment counter; after the 10th bit (stop, data released) go WAIT_ACK.
REQ-022 WAIT_ACK: on next falling edge sample synchronized data: 0 -> WAIT_IDLE; 1 -> oError pulse, go IDLE.
REQ-023 WAIT_IDLE: wait until synchronized clock and data both 1, then oDone pulse one cycle, go IDLE.
REQ-024 A watchdog counter SHALL clear on every falling edge and state change; reaching TIMEOUT_CYCLES in RTS, SEND, WAIT_ACK or WAIT_IDLE -> release both lines, oError pulse, go IDLE.
REQ-025 oDone and oError SHALL never assert in the same cycle; each returns 0 the following cycle; oBusy drops in the same cycle as the pulse.
REQ-026 Block SHALL never drive a line high; only Oe outputs control the bus.

Reset
REQ-027 iReset high SHALL immediately (asynchronously) force IDLE, oPs2ClkOe=0, oPs2DataOe=0, oBusy=0, oDone=0, oError=0, counters and synchronizers cleared to idle-line value 1.
REQ-028 Reset mid-transfer SHALL abort with no oDone/oError pulse; next iStart after reset release starts a fresh frame.

Verification (INHIBIT_CYCLES=8, TIMEOUT_CYCLES=200, device model clocks at 40-cycle period)
REQ-029 iStart with iCmd=0xED -> clock held low 8 cycles, data bits sampled on rising edges 1,0,1,1,0,1,1,1, parity 1, stop 1; device ACK 0 -> single oDone pulse, oBusy low.
REQ-030 iCmd=0x01 -> parity bit 0; iCmd=0x00 -> parity bit 1; both complete with oDone.
REQ-031 Device never clocks after RTS -> oError pulse 200 cycles after RTS entry, both Oe low, no oDone.
REQ-032 Device leaves data high at ACK clock -> oError pulse, IDLE.
REQ-033 iStart pulsed again during SEND with iCmd=0x55 -> ignored; frame content remains 0xED.
REQ-034 iReset asserted after 4th data bit -> both Oe low same cycle, oBusy 0, no pulses; subsequent iStart 0xF4 completes with oDone.
